// File: rtl/osc_clk_enable_gen.sv
// Multi-channel clock-enable generator: per-channel programmable divider producing a
// one-cycle tick and a registered square-wave enable, with divisor changes deferred to a safe point.
module osc_clk_enable_gen #(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 50,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  sync,
  input  logic                  div_wr,
  input  logic [SEL_W-1:0]      div_sel,
  input  logic [DIV_W-1:0]      div_wdata,
  output logic [DIV_W-1:0]      div_rdata,
  output logic [N_CH-1:0]       div_pend,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       clk_out
);

  localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEFAULT_DIV);

  logic [N_CH-1:0][DIV_W-1:0] d_q, d_d;
  logic [N_CH-1:0][DIV_W-1:0] s_q, s_d;
  logic [N_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]            p_q, p_d;
  logic [N_CH-1:0]            tick_q, tick_d;
  logic [N_CH-1:0]            clk_q, clk_d;
  logic [DIV_W-1:0]           rdata_q, rdata_d;

  always_comb begin
    logic [DIV_W-1:0] deff;
    logic [DIV_W-1:0] cnt_nx;
    logic [DIV_W:0]   half;
    logic             tc;
    logic             hit;
    logic             safe;
    d_d     = d_q;
    s_d     = s_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    tick_d  = tick_q;
    clk_d   = clk_q;
    rdata_d = '0;
    deff    = '0;
    cnt_nx  = '0;
    half    = '0;
    tc      = 1'b0;
    hit     = 1'b0;
    safe    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      deff   = (d_q[i] == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : d_q[i];
      tc     = (cnt_q[i] == deff - 1'b1);
      cnt_nx = tc ? '0 : cnt_q[i] + 1'b1;
      half   = ({1'b0, deff} + 1'b1) >> 1;
      hit    = div_wr && (div_sel == SEL_W'(i));
      // Points where the counter restarts at 0, so a new divisor cannot be cut mid-period.
      safe   = !ch_en[i] || tc || sync;

      if (!ch_en[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b0;
        clk_d[i]  = 1'b0;
      end else if (sync) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b0;
        clk_d[i]  = 1'b1;
      end else begin
        cnt_d[i]  = cnt_nx;
        tick_d[i] = tc;
        clk_d[i]  = ({1'b0, cnt_nx} < half);
      end

      // A write landing on a safe point bypasses the shadow and takes effect immediately.
      if (hit) begin
        s_d[i] = div_wdata;
        if (safe) begin
          d_d[i] = div_wdata;
          p_d[i] = 1'b0;
        end else begin
          p_d[i] = 1'b1;
        end
      end else if (p_q[i] && safe) begin
        d_d[i] = s_q[i];
        p_d[i] = 1'b0;
      end

      if (div_sel == SEL_W'(i)) begin
        rdata_d = d_q[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      d_q     <= {N_CH{DEF_D}};
      s_q     <= {N_CH{DEF_D}};
      cnt_q   <= '0;
      p_q     <= '0;
      tick_q  <= '0;
      clk_q   <= '0;
      rdata_q <= '0;
    end else begin
      d_q     <= d_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      tick_q  <= tick_d;
      clk_q   <= clk_d;
      rdata_q <= rdata_d;
    end
  end

  assign div_rdata = rdata_q;
  assign div_pend  = p_q;
  assign tick      = tick_q;
  assign clk_out   = clk_q;

endmodule
